sparse_mem_responder: RTL and testbench
=======================================

# sparse_mem_responder

Synthesizable memory-side responder for the sparse-matrix decoder's `req_mem_*`/`rsp_mem_*` port pair. It accepts tagged 64-bit load requests, reads a local word-addressed array after a fixed pipeline latency and returns tagged responses in order. It honours backpressure in both directions. It replaces the behavioural mock memory in decoder benches and is the base for the on-chip staging memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 48, byte-address width of `req_mem_addr`.
- `TAG_WIDTH`, 2, tag width.
- `DEPTH_LOG2`, 10, log2 of array depth in 64-bit words.
- `LATENCY`, 3, accept-to-FIFO-write pipeline depth; legal range 1..8.
- `FIFO_DEPTH_LOG2`, 3, log2 of response FIFO depth.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_mem_ld`  in  1  load request valid.
- `req_mem_addr`  in  ADDR_WIDTH  byte address; bits [2:0] ignored.
- `req_mem_tag`  in  TAG_WIDTH  request tag, returned unchanged.
- `req_mem_stall`  out  1  responder cannot accept a request this cycle.
- `rsp_mem_push`  out  1  response valid, one beat per cycle.
- `rsp_mem_tag`  out  TAG_WIDTH  tag of the current response.
- `rsp_mem_q`  out  64  read data.
- `rsp_mem_stall`  in  1  requester cannot take a response.
- `init_we`  in  1  array write strobe (bench/host preload).
- `init_addr`  in  DEPTH_LOG2  word address for the write.
- `init_d`  in  64  write data.
- `oor_err`  out  1  sticky out-of-range flag; see Configuration.

## Operation
- A request is accepted when `req_mem_ld && !req_mem_stall` at a rising edge. A request presented while stalled is ignored; the requester holds it.
- Word index is `req_mem_addr[DEPTH_LOG2+2:3]`.
- An accepted request enters a LATENCY-stage shift pipeline of {valid, tag, word index}. The array is read in the final stage and {tag, data} is written into the response FIFO (depth 2^FIFO_DEPTH_LOG2).
- `outstanding` counts pipeline entries plus FIFO entries, with width FIFO_DEPTH_LOG2+1. It increments on accept and decrements on push, and does not change when both happen in the same cycle.
- `req_mem_stall = (outstanding == 2^FIFO_DEPTH_LOG2)`. This is combinational from registers only and independent of `req_mem_ld`. Because of this, the FIFO never overflows.
- Output stage is a registered {push, tag, q}. When the FIFO is non-empty and `rsp_mem_stall` is low, the head is popped into the output registers and `rsp_mem_push` is 1 for that cycle. Otherwise `rsp_mem_push` is 0, and `rsp_mem_tag`/`rsp_mem_q` are driven to 0.
- Responses leave in acceptance order. Tags are never reordered or merged.
- An `init_write` and a pipeline read to the same word in the same cycle: the read returns the old data.
- The array is not cleared by reset.

## Timing
- Reset values: `req_mem_stall`=0, `rsp_mem_push`=0, `rsp_mem_tag`=0, `rsp_mem_q`=0, `oor_err`=0. Pipeline valids, FIFO pointers and `outstanding` are all 0.
- Reset asserted mid-operation flushes every in-flight request and queued response. No response is produced for them after `rst_n` rises.
- Latency: for a request accepted at edge E0, with an empty FIFO and `rsp_mem_stall` low, `rsp_mem_push` is high in the cycle after edge E(LATENCY+1). For LATENCY=3, the response is visible 4 cycles after accept.
- Throughput: 1 request/cycle sustained while `rsp_mem_stall` stays low.
- `rsp_mem_stall` is sampled at the edge that would pop. When it rises, the next cycle shows `rsp_mem_push`=0 and no entry is lost.
- Empty FIFO with `rsp_mem_stall` low: the output is idle (push=0).
- Full: `req_mem_stall` is high in the same cycle `outstanding` reaches capacity. It falls in the cycle after the first pop.

## Configuration
- Macro: `SPARSE_MEM_RSP_BOUNDS_EN`.
- Defined:
  - A request whose address bits [ADDR_WIDTH-1:DEPTH_LOG2+3] are non-zero returns `rsp_mem_q` = 64'hDEADBEEF_DEADBEEF with its own tag.
  - It sets `oor_err` to 1 at the acceptance edge. `oor_err` clears only on reset.
- Undefined:
  - Upper address bits are ignored, so the address wraps modulo the array size.
  - `oor_err` is tied to 0.

## Test plan
- Preload word 5 = 64'h3FF0000000000000 via `init_we`, then request addr 0x28 with tag 2 -> 4 cycles later one push: tag 2, q = 64'h3FF0000000000000.
- Back-to-back requests to words 0..15 with tags cycling 0..3, `rsp_mem_stall` low -> 16 consecutive pushes in order, with matching tags and data.
- Hold `rsp_mem_stall` high and issue requests continuously -> exactly 8 accepted, then `req_mem_stall` high. After releasing the stall, 8 pushes in order with no loss or duplication.
- Toggle `rsp_mem_stall` every cycle during a 32-request stream -> 32 responses, never a push in a cycle following a sampled stall.
- With the macro defined, request addr 1<<13 with tag 1 -> q = 64'hDEADBEEF_DEADBEEF, `oor_err` = 1. Without the macro, the same request returns word 0.
- Pulse `rst_n` low with 5 requests in flight -> all outputs 0 during reset, no pushes afterwards, and preloaded data intact on re-read.

Source files
------------

// File: rtl/sparse_mem_responder.sv
// sparse_mem_responder: memory-side responder for the decoder's req_mem/rsp_mem
// ports. Tagged 64-bit loads go through a LATENCY-stage pipeline. The local
// array is read in the final stage, and the result is queued in an in-order
// response FIFO that drains through a registered output stage.
// Optional feature macro: SPARSE_MEM_RSP_BOUNDS_EN. When defined, addresses
// beyond the array return a poison word and set a sticky oor_err flag.
//
// Handshake semantics:
// - A request transfers on a rising edge where req_mem_ld && !req_mem_stall.
// - req_mem_stall depends only on registers, never on req_mem_ld.
// - A response transfers on every cycle that rsp_mem_push is high.
// - rsp_mem_stall sampled high at an edge blocks the pop at that edge, so the
//   following cycle shows rsp_mem_push low.
module sparse_mem_responder #(
  parameter int ADDR_WIDTH      = 48,
  parameter int TAG_WIDTH       = 2,
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 3,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_mem_ld,
  input  logic [ADDR_WIDTH-1:0] req_mem_addr,
  input  logic [TAG_WIDTH-1:0]  req_mem_tag,
  output logic                  req_mem_stall,
  output logic                  rsp_mem_push,
  output logic [TAG_WIDTH-1:0]  rsp_mem_tag,
  output logic [63:0]           rsp_mem_q,
  input  logic                  rsp_mem_stall,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [63:0]           init_d,
  output logic                  oor_err
);

  localparam int MEM_DEPTH  = 1 << DEPTH_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] CAPACITY = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);
  localparam logic [63:0] OOR_DATA = 64'hDEADBEEF_DEADBEEF;

  logic [63:0]           mem [MEM_DEPTH];
  logic [LATENCY-1:0]    pipe_v;
  logic [TAG_WIDTH-1:0]  pipe_tag [LATENCY];
  logic [DEPTH_LOG2-1:0] pipe_idx [LATENCY];
  logic [LATENCY-1:0]    pipe_oor;

  logic [TAG_WIDTH-1:0]  fifo_tag  [FIFO_DEPTH];
  logic [63:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr, rd_ptr, outstanding;

  logic                  accept, pop, fifo_empty, fifo_wr, req_oor;
  logic [63:0]           rd_data;
  logic                  unused_addr_bits;

  // Byte-offset bits never select anything, and the upper bits only matter
  // when bounds checking is built in.
  assign unused_addr_bits = ^{req_mem_addr[2:0], req_mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+3]};

`ifdef SPARSE_MEM_RSP_BOUNDS_EN
  assign req_oor = |req_mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+3];
`else
  assign req_oor = 1'b0;
`endif

  assign req_mem_stall = (outstanding == CAPACITY);
  assign accept        = req_mem_ld && !req_mem_stall;
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign pop           = !fifo_empty && !rsp_mem_stall;
  assign fifo_wr       = pipe_v[LATENCY-1];

  // Final-stage read. The array is read before any same-edge init write
  // lands, so a colliding read returns the old word.
  always_comb begin
    rd_data = mem[pipe_idx[LATENCY-1]];
    if (pipe_oor[LATENCY-1]) rd_data = OOR_DATA;
  end

  // Host preload port; the array deliberately survives reset.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_d;
  end

  // Request pipeline: stage 0 captures an accepted request, then shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v   <= '0;
      pipe_oor <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag[i] <= '0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= accept;
      pipe_oor[0] <= accept && req_oor;
      pipe_tag[0] <= req_mem_tag;
      pipe_idx[0] <= req_mem_addr[DEPTH_LOG2+2:3];
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_oor[i] <= pipe_oor[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  // Response FIFO storage; the stall threshold guarantees it never overflows.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_tag[wr_ptr[FIFO_DEPTH_LOG2-1:0]]  <= pipe_tag[LATENCY-1];
      fifo_data[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= rd_data;
    end
  end

  // FIFO pointers and the in-flight count (pipeline plus FIFO entries).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      outstanding <= outstanding + 1'b1;
      else if (!accept && pop) outstanding <= outstanding - 1'b1;
    end
  end

  // Registered output stage; tag and data read as zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mem_push <= 1'b0;
      rsp_mem_tag  <= '0;
      rsp_mem_q    <= '0;
    end else begin
      rsp_mem_push <= pop;
      rsp_mem_tag  <= pop ? fifo_tag[rd_ptr[FIFO_DEPTH_LOG2-1:0]] : '0;
      rsp_mem_q    <= pop ? fifo_data[rd_ptr[FIFO_DEPTH_LOG2-1:0]] : '0;
    end
  end

`ifdef SPARSE_MEM_RSP_BOUNDS_EN
  // Sticky out-of-range flag, set at the accepting edge; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                oor_err <= 1'b0;
    else if (accept && req_oor) oor_err <= 1'b1;
  end
`else
  assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_mem_responder.sv
// tb_sparse_mem_responder: self-checking bench for sparse_mem_responder.
// Builds with or without SPARSE_MEM_RSP_BOUNDS_EN; the expected values follow
// the macro.
module tb_sparse_mem_responder;

  localparam int AW = 48;
  localparam int TW = 2;
  localparam int DL = 10;
  localparam int EW = TW + 64;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_mem_ld = 1'b0;
  logic [AW-1:0] req_mem_addr = '0;
  logic [TW-1:0] req_mem_tag = '0;
  logic          req_mem_stall;
  logic          rsp_mem_push;
  logic [TW-1:0] rsp_mem_tag;
  logic [63:0]   rsp_mem_q;
  logic          rsp_mem_stall = 1'b0;
  logic          init_we = 1'b0;
  logic [DL-1:0] init_addr = '0;
  logic [63:0]   init_d = '0;
  logic          oor_err;

  always #5 clk = ~clk;

  sparse_mem_responder #(
    .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH_LOG2(DL), .LATENCY(3), .FIFO_DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_mem_ld(req_mem_ld), .req_mem_addr(req_mem_addr), .req_mem_tag(req_mem_tag),
    .req_mem_stall(req_mem_stall),
    .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
    .rsp_mem_stall(rsp_mem_stall),
    .init_we(init_we), .init_addr(init_addr), .init_d(init_d),
    .oor_err(oor_err)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0]   model_mem [0:(1<<DL)-1];
  int   push_count = 0;
  int   run_len = 0;
  int   max_run = 0;
  logic last_stall = 1'b0;
  logic toggle_en = 1'b0;

`ifdef SPARSE_MEM_RSP_BOUNDS_EN
  localparam logic BOUNDS_ON = 1'b1;
`else
  localparam logic BOUNDS_ON = 1'b0;
`endif

  function automatic logic [EW-1:0] expect_rsp(input logic [AW-1:0] a, input logic [TW-1:0] t);
    logic [DL-1:0] idx;
    logic          oor;
    idx = a[DL+2:3];
    oor = |a[AW-1:DL+3];
    if (BOUNDS_ON && oor) return {t, 64'hDEADBEEF_DEADBEEF};
    return {t, model_mem[idx]};
  endfunction

  // Response monitor: every push is popped from the expected queue and must
  // not follow a cycle in which rsp_mem_stall was presented high.
  always @(negedge clk) begin
    logic [EW-1:0] exp;
    if (rsp_mem_push === 1'b1) begin
      push_count++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_push: got tag=%0d q=%h, required no push", rsp_mem_tag, rsp_mem_q);
      end else begin
        exp = exp_q.pop_front();
        if ({rsp_mem_tag, rsp_mem_q} !== exp) begin
          tests_failed++;
          $display("FAIL rsp_data: got tag=%0d q=%h, required tag=%0d q=%h",
                   rsp_mem_tag, rsp_mem_q, exp[EW-1:64], exp[63:0]);
        end
      end
      tests_run++;
      if (last_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL push_after_stall: got push=1 after sampled stall, required push=0");
      end
    end else begin
      run_len = 0;
    end
    last_stall = rsp_mem_stall;
  end

  // Free-running stall toggler used by the toggle scenario.
  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      rsp_mem_stall = ~rsp_mem_stall;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input int idx, input logic [63:0] d);
    @(posedge clk); #1;
    init_we = 1'b1; init_addr = DL'(idx); init_d = d;
    model_mem[idx] = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // Presents one request and holds it until accepted; expectation is queued
  // once the stall sampled ahead of the accepting edge is low.
  task automatic send(input logic [AW-1:0] a, input logic [TW-1:0] t);
    int  waited = 0;
    bit  done = 0;
    while (!done) begin
      @(posedge clk); #1;
      req_mem_ld = 1'b1; req_mem_addr = a; req_mem_tag = t;
      @(negedge clk);
      if (req_mem_stall === 1'b0) begin
        exp_q.push_back(expect_rsp(a, t));
        done = 1;
      end else begin
        waited++;
        if (waited > 300) begin
          tests_run++; tests_failed++;
          $display("FAIL send_timeout: got stall for %0d cycles, required accept", waited);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    req_mem_ld = 1'b0;
  endtask

  task automatic wait_pushes(input int target, input int budget, input string name);
    int n = 0;
    while (push_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    tests_run++;
    if (push_count != target) begin
      tests_failed++;
      $display("FAIL %s: got %0d pushes, required %0d", name, push_count, target);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, oor_err} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got stall=%b push=%b tag=%0d q=%h oor=%b, required all 0",
               req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, oor_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (req_mem_stall !== 1'b0 || rsp_mem_push !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got stall=%b push=%b, required 0 0", req_mem_stall, rsp_mem_push);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 32; i++) preload(i, {$urandom(), $urandom()});
    preload(5, 64'h3FF0000000000000);
    send(AW'(48'h28), 2'd2);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (rsp_mem_push !== (i == 4)) begin
        tests_failed++;
        $display("FAIL latency_cycle%0d: got push=%b, required %b", i, rsp_mem_push, (i == 4));
      end
    end
    tests_run++;
    if (rsp_mem_tag !== 2'd2 || rsp_mem_q !== 64'h3FF0000000000000) begin
      tests_failed++;
      $display("FAIL single_word5: got tag=%0d q=%h, required tag=2 q=3ff0000000000000", rsp_mem_tag, rsp_mem_q);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    #1;
    base = push_count;
    max_run = 0;
    for (int i = 0; i < 16; i++) send(AW'(i * 8), TW'(i % 4));
    idle();
    wait_pushes(base + 16, 60, "b2b_count");
    tests_run++;
    if (max_run != 16) begin
      tests_failed++;
      $display("FAIL b2b_consecutive: got longest run %0d, required 16", max_run);
    end
  endtask

  task automatic test_full();
    int base;
    int acc = 0;
    int first_seen = 0;
    @(posedge clk); #1;
    rsp_mem_stall = 1'b1;
    base = push_count;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      req_mem_ld = 1'b1; req_mem_addr = AW'((8 + acc) * 8); req_mem_tag = TW'(acc % 4);
      @(negedge clk);
      if (req_mem_stall === 1'b0) begin
        exp_q.push_back(expect_rsp(req_mem_addr, req_mem_tag));
        acc++;
      end
    end
    #1;
    tests_run++;
    if (acc != 8) begin
      tests_failed++;
      $display("FAIL full_accepted: got %0d accepted, required 8", acc);
    end
    tests_run++;
    if (req_mem_stall !== 1'b1 || push_count != base) begin
      tests_failed++;
      $display("FAIL full_stalled: got stall=%b pushes=%0d, required stall=1 pushes=0",
               req_mem_stall, push_count - base);
    end
    max_run = 0;
    @(posedge clk); #1;
    req_mem_ld = 1'b0;
    rsp_mem_stall = 1'b0;
    for (int i = 0; i < 10 && first_seen == 0; i++) begin
      @(negedge clk);
      if (rsp_mem_push === 1'b1) begin
        first_seen = 1;
        tests_run++;
        if (req_mem_stall !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_release: got req_mem_stall=%b after first pop, required 0", req_mem_stall);
        end
      end
    end
    wait_pushes(base + 8, 40, "full_drain_count");
    tests_run++;
    if (max_run != 8 || first_seen == 0) begin
      tests_failed++;
      $display("FAIL full_drain_run: got run %0d seen=%0d, required 8 1", max_run, first_seen);
    end
  endtask

  task automatic test_toggle();
    int base;
    #1;
    base = push_count;
    @(posedge clk); #1;
    toggle_en = 1'b1;
    for (int i = 0; i < 32; i++) send(AW'(i * 8), TW'(i % 4));
    idle();
    toggle_en = 1'b0;
    @(posedge clk); #1;
    rsp_mem_stall = 1'b0;
    wait_pushes(base + 32, 200, "toggle_count");
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL toggle_leftover: got %0d queued, required 0", exp_q.size());
    end
  endtask

  task automatic test_oor();
    int base;
    #1;
    base = push_count;
    send(AW'(1) << 13, 2'd1);
    idle();
    wait_pushes(base + 1, 20, "oor_count");
    tests_run++;
    if (oor_err !== BOUNDS_ON) begin
      tests_failed++;
      $display("FAIL oor_flag: got oor_err=%b, required %b", oor_err, BOUNDS_ON);
    end
  endtask

  task automatic test_reset_flush();
    int pc;
    for (int i = 0; i < 5; i++) send(AW'(i * 8), TW'(i % 4));
    @(posedge clk); #1;
    req_mem_ld = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, oor_err} !== '0) begin
      tests_failed++;
      $display("FAIL flush_outputs: got stall=%b push=%b tag=%0d q=%h oor=%b, required all 0",
               req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q, oor_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pc = push_count;
    repeat (20) @(negedge clk);
    #1;
    tests_run++;
    if (push_count != pc) begin
      tests_failed++;
      $display("FAIL flush_no_push: got %0d pushes after reset, required 0", push_count - pc);
    end
    send(AW'(5 * 8), 2'd3);
    send(AW'(3 * 8), 2'd0);
    idle();
    wait_pushes(pc + 2, 20, "reread_count");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_toggle();
    test_oor();
    test_reset_flush();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
